// File: rtl/vmul_issue_arb_if.sv
// rtl/vmul_issue_arb_if.sv - op offer/accept bundle between one vector lane decode stage and the vMul issue arbiter
interface vmul_issue_arb_if #(
   parameter int DATA_WIDTH  = 64,
   parameter int ADDR_WIDTH  = 32,
   parameter int SEW_WIDTH   = 2,
   parameter int OPSEL_WIDTH = 2
) ();
   logic                   valid;
   logic                   ready;
   logic [DATA_WIDTH-1:0]  vec0;
   logic [DATA_WIDTH-1:0]  vec1;
   logic [SEW_WIDTH-1:0]   sew;
   logic [OPSEL_WIDTH-1:0] opsel;
   logic                   widen;
   logic [ADDR_WIDTH-1:0]  addr;
   logic                   last;

   // requester side: offers ops, observes acceptance
   modport master (
      output valid, vec0, vec1, sew, opsel, widen, addr, last,
      input  ready
   );

   // arbiter side: consumes ops, returns acceptance
   modport slave (
      input  valid, vec0, vec1, sew, opsel, widen, addr, last,
      output ready
   );
endinterface

// File: rtl/vmul_issue_arb.sv
// rtl/vmul_issue_arb.sv - two-requester vMul issue arbiter and response router (optional perf counters: VMUL_ARB_PERF_EN)
module vmul_issue_arb #(
   parameter int REQ_DATA_WIDTH = 64,
   parameter int REQ_ADDR_WIDTH = 32,
   parameter int SEW_WIDTH      = 2,
   parameter int OPSEL_WIDTH    = 2,
   parameter int MUL_LATENCY    = 6
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,

   vmul_issue_arb_if.slave           req0_if,
   vmul_issue_arb_if.slave           req1_if,

   output logic [REQ_DATA_WIDTH-1:0] mul_vec0_o,
   output logic [REQ_DATA_WIDTH-1:0] mul_vec1_o,
   output logic [SEW_WIDTH-1:0]      mul_sew_o,
   output logic [OPSEL_WIDTH-1:0]    mul_opsel_o,
   output logic                      mul_widen_o,
   output logic [REQ_ADDR_WIDTH-1:0] mul_addr_o,
   output logic                      mul_valid_o,

   input  logic                      mul_out_valid_i,
   input  logic [REQ_DATA_WIDTH-1:0] mul_out_vec_i,
   input  logic [REQ_ADDR_WIDTH-1:0] mul_out_addr_i,

   output logic                      rsp0_valid_o,
   output logic                      rsp1_valid_o,
   output logic [REQ_DATA_WIDTH-1:0] rsp_vec_o,
   output logic [REQ_ADDR_WIDTH-1:0] rsp_addr_o,

   input  logic                      flush_i,
   output logic                      flush_done_o,
   output logic                      busy_o,
   output logic                      err_orphan_o
`ifdef VMUL_ARB_PERF_EN
   ,
   output logic [31:0]               perf_issue0_o,
   output logic [31:0]               perf_issue1_o,
   output logic [31:0]               perf_conflict_o
`endif
);

   // One tag stage per cycle between accept and the vMul result strobe.
   localparam int TAG_DEPTH = MUL_LATENCY + 1;
   localparam int CNT_WIDTH = $clog2(TAG_DEPTH + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(TAG_DEPTH);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOCK0 = 2'd1;
   localparam logic [1:0] ST_LOCK1 = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   logic [1:0]                state_q, state_d;
   logic                      rr_q, rr_d;
   logic                      gnt0, gnt1;
   logic                      acc_any, acc_id, acc_last;

   logic [TAG_DEPTH-1:0]      tag_v_q, tag_v_d;
   logic [TAG_DEPTH-1:0]      tag_id_q, tag_id_d;
   logic                      tail_v, tail_id;
   logic                      rsp_fire;

   logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
   logic                      done_q, done_d;
   logic                      err_q, err_d;
   logic                      flush_done;

   logic [REQ_DATA_WIDTH-1:0] mul_vec0_q, mul_vec0_d;
   logic [REQ_DATA_WIDTH-1:0] mul_vec1_q, mul_vec1_d;
   logic [SEW_WIDTH-1:0]      mul_sew_q, mul_sew_d;
   logic [OPSEL_WIDTH-1:0]    mul_opsel_q, mul_opsel_d;
   logic                      mul_widen_q, mul_widen_d;
   logic [REQ_ADDR_WIDTH-1:0] mul_addr_q, mul_addr_d;
   logic                      mul_valid_q, mul_valid_d;

   // Grant: flush blocks everything; a lock pins the grant to its owner; otherwise round-robin on contention.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!flush_i) begin
         case (state_q)
            ST_IDLE: begin
               if (req0_if.valid && req1_if.valid) begin
                  gnt0 = ~rr_q;
                  gnt1 = rr_q;
               end else begin
                  gnt0 = req0_if.valid;
                  gnt1 = req1_if.valid;
               end
            end
            ST_LOCK0: gnt0 = req0_if.valid;
            ST_LOCK1: gnt1 = req1_if.valid;
            default: ;
         endcase
      end
   end

   assign req0_if.ready = gnt0;
   assign req1_if.ready = gnt1;

   assign acc_any  = gnt0 | gnt1;
   assign acc_id   = gnt1;
   assign acc_last = gnt1 ? req1_if.last : req0_if.last;

   // Next FSM state and round-robin pointer (pointer always moves away from the requester just served).
   always_comb begin
      state_d = state_q;
      rr_d    = acc_any ? ~acc_id : rr_q;
      if (flush_i) begin
         state_d = ST_DRAIN;
      end else begin
         case (state_q)
            ST_IDLE:  if (acc_any && !acc_last) state_d = acc_id ? ST_LOCK1 : ST_LOCK0;
            ST_LOCK0,
            ST_LOCK1: if (acc_any && acc_last) state_d = ST_IDLE;
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   assign tail_v   = tag_v_q[TAG_DEPTH-1];
   assign tail_id  = tag_id_q[TAG_DEPTH-1];
   assign rsp_fire = mul_out_valid_i & tail_v;

   // Tag pipe shift, in-flight bookkeeping, orphan detection and the one-shot drain pulse.
   always_comb begin
      tag_v_d  = {tag_v_q[TAG_DEPTH-2:0], acc_any};
      tag_id_d = {tag_id_q[TAG_DEPTH-2:0], acc_id};

      cnt_d = cnt_q;
      if (acc_any && !rsp_fire && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end else if (!acc_any && rsp_fire && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end

      // A result without a tag, or a tag whose result never showed up, means issue and vMul disagree.
      err_d = err_q | (mul_out_valid_i ^ tail_v);

      flush_done = (state_q == ST_DRAIN) && (cnt_q == '0) && !done_q;
      done_d     = (state_q == ST_DRAIN) ? (done_q | flush_done) : 1'b0;
   end

   // Issue register: capture the winning op; data is held between issues so vMul inputs stay quiet.
   always_comb begin
      mul_vec0_d  = mul_vec0_q;
      mul_vec1_d  = mul_vec1_q;
      mul_sew_d   = mul_sew_q;
      mul_opsel_d = mul_opsel_q;
      mul_widen_d = mul_widen_q;
      mul_addr_d  = mul_addr_q;
      mul_valid_d = acc_any;
      if (gnt1) begin
         mul_vec0_d  = req1_if.vec0;
         mul_vec1_d  = req1_if.vec1;
         mul_sew_d   = req1_if.sew;
         mul_opsel_d = req1_if.opsel;
         mul_widen_d = req1_if.widen;
         mul_addr_d  = req1_if.addr;
      end else if (gnt0) begin
         mul_vec0_d  = req0_if.vec0;
         mul_vec1_d  = req0_if.vec1;
         mul_sew_d   = req0_if.sew;
         mul_opsel_d = req0_if.opsel;
         mul_widen_d = req0_if.widen;
         mul_addr_d  = req0_if.addr;
      end
   end

   // Control state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         rr_q     <= 1'b0;
         tag_v_q  <= '0;
         tag_id_q <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         tag_v_q  <= tag_v_d;
         tag_id_q <= tag_id_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   // Issue registers towards vMul.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mul_vec0_q  <= '0;
         mul_vec1_q  <= '0;
         mul_sew_q   <= '0;
         mul_opsel_q <= '0;
         mul_widen_q <= 1'b0;
         mul_addr_q  <= '0;
         mul_valid_q <= 1'b0;
      end else begin
         mul_vec0_q  <= mul_vec0_d;
         mul_vec1_q  <= mul_vec1_d;
         mul_sew_q   <= mul_sew_d;
         mul_opsel_q <= mul_opsel_d;
         mul_widen_q <= mul_widen_d;
         mul_addr_q  <= mul_addr_d;
         mul_valid_q <= mul_valid_d;
      end
   end

   assign mul_vec0_o   = mul_vec0_q;
   assign mul_vec1_o   = mul_vec1_q;
   assign mul_sew_o    = mul_sew_q;
   assign mul_opsel_o  = mul_opsel_q;
   assign mul_widen_o  = mul_widen_q;
   assign mul_addr_o   = mul_addr_q;
   assign mul_valid_o  = mul_valid_q;

   // Results route straight through; only the owner strobe depends on the tag.
   assign rsp0_valid_o = rsp_fire & ~tail_id;
   assign rsp1_valid_o = rsp_fire & tail_id;
   assign rsp_vec_o    = mul_out_vec_i;
   assign rsp_addr_o   = mul_out_addr_i;

   assign flush_done_o = flush_done;
   assign busy_o       = (cnt_q != '0);
   assign err_orphan_o = err_q;

`ifdef VMUL_ARB_PERF_EN
   logic [31:0] perf_issue0_q, perf_issue0_d;
   logic [31:0] perf_issue1_q, perf_issue1_d;
   logic [31:0] perf_conflict_q, perf_conflict_d;
   logic        conflict;

   // Contention: both lanes offering while at most one of them is served.
   assign conflict = req0_if.valid & req1_if.valid & ~(gnt0 & gnt1);

   // Saturating event counters.
   always_comb begin
      perf_issue0_d   = perf_issue0_q;
      perf_issue1_d   = perf_issue1_q;
      perf_conflict_d = perf_conflict_q;
      if (gnt0 && (perf_issue0_q != '1))     perf_issue0_d   = perf_issue0_q + 32'd1;
      if (gnt1 && (perf_issue1_q != '1))     perf_issue1_d   = perf_issue1_q + 32'd1;
      if (conflict && (perf_conflict_q != '1)) perf_conflict_d = perf_conflict_q + 32'd1;
   end

   // Counter registers, cleared only by reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_issue0_q   <= '0;
         perf_issue1_q   <= '0;
         perf_conflict_q <= '0;
      end else begin
         perf_issue0_q   <= perf_issue0_d;
         perf_issue1_q   <= perf_issue1_d;
         perf_conflict_q <= perf_conflict_d;
      end
   end

   assign perf_issue0_o   = perf_issue0_q;
   assign perf_issue1_o   = perf_issue1_q;
   assign perf_conflict_o = perf_conflict_q;
`endif

endmodule

// File: tb/tb_vmul_issue_arb.sv
// tb/tb_vmul_issue_arb.sv - directed scoreboard bench for vmul_issue_arb with a behavioural 6-cycle vMul
module tb_vmul_issue_arb;
   localparam int DW = 64;
   localparam int AW = 32;
   localparam int SW = 2;
   localparam int OW = 2;
   localparam int ML = 6;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   vmul_issue_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEW_WIDTH(SW), .OPSEL_WIDTH(OW)) r0 ();
   vmul_issue_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEW_WIDTH(SW), .OPSEL_WIDTH(OW)) r1 ();

   logic [DW-1:0] mul_vec0, mul_vec1, mul_out_vec, rsp_vec;
   logic [SW-1:0] mul_sew;
   logic [OW-1:0] mul_opsel;
   logic          mul_widen, mul_valid, mul_out_valid;
   logic [AW-1:0] mul_addr, mul_out_addr, rsp_addr;
   logic          rsp0_valid, rsp1_valid, flush_done, busy, err_orphan;
   logic          flush = 1'b0;
   logic          inj   = 1'b0;
`ifdef VMUL_ARB_PERF_EN
   logic [31:0]   perf_issue0, perf_issue1, perf_conflict;
`endif

   vmul_issue_arb #(
      .REQ_DATA_WIDTH(DW), .REQ_ADDR_WIDTH(AW), .SEW_WIDTH(SW), .OPSEL_WIDTH(OW), .MUL_LATENCY(ML)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req0_if(r0), .req1_if(r1),
      .mul_vec0_o(mul_vec0), .mul_vec1_o(mul_vec1), .mul_sew_o(mul_sew), .mul_opsel_o(mul_opsel),
      .mul_widen_o(mul_widen), .mul_addr_o(mul_addr), .mul_valid_o(mul_valid),
      .mul_out_valid_i(mul_out_valid), .mul_out_vec_i(mul_out_vec), .mul_out_addr_i(mul_out_addr),
      .rsp0_valid_o(rsp0_valid), .rsp1_valid_o(rsp1_valid), .rsp_vec_o(rsp_vec), .rsp_addr_o(rsp_addr),
      .flush_i(flush), .flush_done_o(flush_done), .busy_o(busy), .err_orphan_o(err_orphan)
`ifdef VMUL_ARB_PERF_EN
      , .perf_issue0_o(perf_issue0), .perf_issue1_o(perf_issue1), .perf_conflict_o(perf_conflict)
`endif
   );

   // Behavioural vMul: low 32-bit product, fixed latency, no backpressure.
   logic [ML-1:0] pv;
   logic [DW-1:0] pvec [ML];
   logic [AW-1:0] padr [ML];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pv <= '0;
      end else begin
         pv      <= {pv[ML-2:0], mul_valid};
         pvec[0] <= {32'd0, mul_vec0[31:0] * mul_vec1[31:0]};
         padr[0] <= mul_addr;
         for (int i = 1; i < ML; i++) begin
            pvec[i] <= pvec[i-1];
            padr[i] <= padr[i-1];
         end
      end
   end
   assign mul_out_valid = pv[ML-1] | inj;
   assign mul_out_vec   = pvec[ML-1];
   assign mul_out_addr  = padr[ML-1];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int            due;
      bit            id;
      logic [DW-1:0] vec;
      logic [AW-1:0] addr;
   } exp_t;
   exp_t sb[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input bit id, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [AW-1:0] ad);
      exp_t e;
      logic [31:0] p;
      p      = a[31:0] * b[31:0];
      e.due  = cyc + ML + 1;
      e.id   = id;
      e.vec  = {32'd0, p};
      e.addr = ad;
      sb.push_back(e);
   endtask

   // Response monitor: every cycle either the scoreboard head is due or no response may appear.
   always begin
      @(negedge clk);
      #1;
      if (sb.size() > 0 && sb[0].due == cyc) begin
         exp_t e;
         e = sb.pop_front();
         chk("rsp0_valid", rsp0_valid, e.id == 1'b0);
         chk("rsp1_valid", rsp1_valid, e.id == 1'b1);
         chk("rsp_vec", rsp_vec, e.vec);
         chk("rsp_addr", rsp_addr, e.addr);
      end else begin
         chk("rsp0_idle", rsp0_valid, 0);
         chk("rsp1_idle", rsp1_valid, 0);
      end
   end

   bit rand_data = 1'b1;

   // One clock of stimulus: drive at the falling edge, check readys, record expected results.
   task automatic drive(input bit v0, input bit l0, input bit v1, input bit l1, input bit fl,
                        input bit er0, input bit er1);
      @(negedge clk);
      if (rand_data) begin
         r0.vec0 = {$urandom, $urandom}; r0.vec1 = {$urandom, $urandom};
         r0.addr = $urandom; r0.sew = 2'($urandom_range(0, 3)); r0.opsel = 2'($urandom_range(0, 3));
         r1.vec0 = {$urandom, $urandom}; r1.vec1 = {$urandom, $urandom};
         r1.addr = $urandom; r1.sew = 2'($urandom_range(0, 3)); r1.opsel = 2'($urandom_range(0, 3));
      end
      r0.valid = v0; r0.last = l0;
      r1.valid = v1; r1.last = l1;
      flush    = fl;
      #1;
      chk("ready0", r0.ready, er0);
      chk("ready1", r1.ready, er1);
      if (er0) push_exp(1'b0, r0.vec0, r0.vec1, r0.addr);
      if (er1) push_exp(1'b1, r1.vec0, r1.vec1, r1.addr);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      r0.valid = 1'b0; r1.valid = 1'b0; flush = 1'b0; inj = 1'b0;
      rst_n = 1'b0;
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   int t0;
   bit got;

   initial begin
      r0.valid = 0; r0.last = 0; r0.widen = 0; r0.vec0 = 0; r0.vec1 = 0; r0.sew = 0; r0.opsel = 0; r0.addr = 0;
      r1.valid = 0; r1.last = 0; r1.widen = 0; r1.vec0 = 0; r1.vec1 = 0; r1.sew = 0; r1.opsel = 0; r1.addr = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_mul_valid", mul_valid, 0);
      chk("rst_mul_vec0", mul_vec0, 0);
      chk("rst_busy", busy, 0);
      chk("rst_flush_done", flush_done, 0);
      chk("rst_err", err_orphan, 0);

      // Test 1: single op from req0, 3*5 at sew=32b
      rand_data = 1'b0;
      r0.vec0 = 64'd3; r0.vec1 = 64'd5; r0.sew = 2'b10; r0.opsel = 2'b01; r0.addr = 32'h1000;
      drive(1, 1, 0, 0, 0, 1, 0);
      t0 = cyc;
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("t1_mul_valid", mul_valid, 1);
      chk("t1_mul_vec0", mul_vec0, 3);
      chk("t1_mul_vec1", mul_vec1, 5);
      chk("t1_mul_sew", mul_sew, 2'b10);
      chk("t1_mul_opsel", mul_opsel, 2'b01);
      chk("t1_mul_addr", mul_addr, 32'h1000);
      chk("t1_busy", busy, 1);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("t1_mul_valid_pulse", mul_valid, 0);
      chk("t1_mul_vec0_held", mul_vec0, 3);
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         if (rsp0_valid) begin
            got = 1'b1;
            break;
         end
      end
      chk("t1_rsp_seen", got, 1);
      chk("t1_latency", cyc - t0, ML + 1);
      chk("t1_rsp_vec", rsp_vec, 64'd15);
      chk("t1_rsp1", rsp1_valid, 0);
      rand_data = 1'b1;
      idle(2);
      chk("t1_busy_clear", busy, 0);

      // Test 2: four ops each, both offering -> strict alternation starting at req0
      apply_reset();
      for (int k = 0; k < 8; k++) begin
         drive(k < 7, 1, 1, 1, 0, (k % 2) == 0, (k % 2) == 1);
      end
      idle(ML + 3);
      chk("t2_busy_clear", busy, 0);
`ifdef VMUL_ARB_PERF_EN
      chk("t2_perf_issue0", perf_issue0, 4);
      chk("t2_perf_issue1", perf_issue1, 4);
      chk("t2_perf_conflict", perf_conflict, 7);
`endif

      // Test 3: req0 locks for a 4-beat group (with a bubble), req1 waits
      apply_reset();
      drive(1, 0, 1, 1, 0, 1, 0);
      drive(1, 0, 1, 1, 0, 1, 0);
      drive(0, 0, 1, 1, 0, 0, 0);
      drive(1, 0, 1, 1, 0, 1, 0);
      drive(1, 1, 1, 1, 0, 1, 0);
      drive(0, 0, 1, 1, 0, 0, 1);
      idle(ML + 3);

      // Test 4: three in flight, flush, single drain pulse as the last result retires
      apply_reset();
      drive(1, 1, 0, 0, 0, 1, 0);
      drive(1, 1, 0, 0, 0, 1, 0);
      drive(1, 1, 0, 0, 0, 1, 0);
      for (int k = 1; k <= 9; k++) begin
         drive(1, 1, 1, 1, 1, 0, 0);
         chk("t4_flush_done", flush_done, k == 8);
         chk("t4_busy", busy, k < 8);
      end
      drive(1, 1, 0, 0, 0, 0, 0);
      drive(1, 1, 0, 0, 0, 1, 0);
      idle(ML + 3);
      chk("t4_err", err_orphan, 0);

      // Test 5: async reset with ops in flight, then an untagged result
      apply_reset();
      for (int k = 0; k < 4; k++) drive(0, 0, 1, 1, 0, 0, 1);
      @(negedge clk);
      r1.valid = 1'b0;
      #1;
      chk("t5_pre_mul_valid", mul_valid, 1);
      chk("t5_pre_busy", busy, 1);
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk("t5_rst_mul_valid", mul_valid, 0);
      chk("t5_rst_mul_vec0", mul_vec0, 0);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_ready1", r1.ready, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      inj = 1'b1;
      #1;
      chk("t5_inj_rsp0", rsp0_valid, 0);
      chk("t5_inj_rsp1", rsp1_valid, 0);
      chk("t5_inj_err_before", err_orphan, 0);
      @(negedge clk);
      inj = 1'b0;
      #1;
      chk("t5_err_set", err_orphan, 1);
      chk("t5_busy_no_wrap", busy, 0);
      repeat (3) @(negedge clk);
      #1;
      chk("t5_err_sticky", err_orphan, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
